// File: rtl/axis_fifo_stats.sv
// AXI4-Stream FIFO with flush and fill/high-water/drop statistics for the capture path.
// Latency: one cycle from S acceptance to M presentation when empty; 1 beat/cycle sustained.
// Backpressure: TREADY low when full, or always ready and discarding when full (DROP_WHEN_FULL=1).
module axis_fifo_stats #(
    parameter int TDATA_WIDTH    = 128,
    parameter int FIFO_DEPTH     = 256,
    parameter int DROP_WHEN_FULL = 0,
    parameter int COUNT_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                   S_AXIS_TLAST,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TLAST,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    input  logic                   flush,
    input  logic                   stat_clear,
    output logic [31:0]            data_count,
    output logic [31:0]            max_count,
    output logic [31:0]            drop_count
);
    localparam int RAM_DEPTH = FIFO_DEPTH - 1;
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam bit DROP_MODE = (DROP_WHEN_FULL != 0);
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]   PTR_LAST = PTR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0]   PTR_ONE  = PTR_WIDTH'(1);

    typedef struct packed {
        logic                   last;
        logic [TDATA_WIDTH-1:0] data;
    } beat_t;

    beat_t                  ram [RAM_DEPTH];
    beat_t                  out_q;
    beat_t                  in_beat;
    logic                   out_vld;
    logic                   s_rdy;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic [COUNT_WIDTH-1:0] ram_count;
    logic [31:0]            count_nxt_ext;
    logic [31:0]            max_q;
    logic [31:0]            drop_q;

    logic full, in_vld, accept, drop, pop, out_free, ram_vld, load_ram, load_byp, ram_wr;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign in_beat   = '{last: S_AXIS_TLAST, data: S_AXIS_TDATA};
    assign full      = (count_q == FULL_CNT);
    // Beats offered during a flush vanish without being counted as drops.
    assign in_vld    = S_AXIS_TVALID && s_rdy && !flush;
    assign accept    = in_vld && !full;
    assign drop      = in_vld && full && DROP_MODE;
    assign pop       = out_vld && M_AXIS_TREADY;
    assign out_free  = !out_vld || pop;
    assign ram_count = count_q - COUNT_WIDTH'(out_vld);
    assign ram_vld   = (ram_count != '0);
    assign load_ram  = out_free && ram_vld;
    // Empty RAM and a free output register: the incoming beat goes straight to the output.
    assign load_byp  = out_free && !ram_vld && accept;
    assign ram_wr    = accept && !load_byp;

    always_comb begin
        count_nxt = count_q;
        if (flush)
            count_nxt = '0;
        else if (accept && !pop)
            count_nxt = count_q + CNT_ONE;
        else if (!accept && pop)
            count_nxt = count_q - CNT_ONE;
    end

    assign count_nxt_ext = 32'(count_nxt);

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_q   <= '0;
            out_vld <= 1'b0;
            s_rdy   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            max_q   <= '0;
            drop_q  <= '0;
        end else begin
            // Registered ready; a pop on a full cycle only reopens the input next cycle.
            s_rdy   <= DROP_MODE ? 1'b1 : (count_nxt != FULL_CNT);
            count_q <= count_nxt;
            if (flush) begin
                out_vld <= 1'b0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (load_ram) begin
                    out_q   <= ram[rd_ptr];
                    out_vld <= 1'b1;
                    rd_ptr  <= ptr_inc(rd_ptr);
                end else if (load_byp) begin
                    out_q   <= in_beat;
                    out_vld <= 1'b1;
                end else if (pop) begin
                    out_vld <= 1'b0;
                end
                if (ram_wr)
                    wr_ptr <= ptr_inc(wr_ptr);
            end
            if (stat_clear)
                max_q <= count_nxt_ext;
            else if (count_nxt_ext > max_q)
                max_q <= count_nxt_ext;
            if (stat_clear)
                drop_q <= {31'b0, drop};
            else if (drop && (drop_q != '1))
                drop_q <= drop_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && ram_wr)
            ram[wr_ptr] <= in_beat;
    end

    assign S_AXIS_TREADY = s_rdy;
    assign M_AXIS_TVALID = out_vld;
    assign M_AXIS_TDATA  = out_q.data;
    assign M_AXIS_TLAST  = out_q.last;
    assign data_count    = 32'(count_q);
    assign max_count     = max_q;
    assign drop_count    = drop_q;
endmodule

// File: tb/tb_axis_fifo_stats.sv
// Drives a backpressure and a drop-mode instance with identical stimulus; a queue model predicts both.
module tb_axis_fifo_stats;
    localparam int W = 32;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         areset, s_vld, s_last, m_rdy, flush, stat_clear;
    logic [W-1:0] s_dat;
    logic         s_rdy  [2];
    logic [W-1:0] m_dat  [2];
    logic         m_last [2];
    logic         m_vld  [2];
    logic [31:0]  dcnt   [2];
    logic [31:0]  mcnt   [2];
    logic [31:0]  dropc  [2];

    axis_fifo_stats #(.TDATA_WIDTH(W), .FIFO_DEPTH(D), .DROP_WHEN_FULL(0)) dut_bp (
        .aclk(clk), .areset(areset),
        .S_AXIS_TDATA(s_dat), .S_AXIS_TLAST(s_last), .S_AXIS_TVALID(s_vld), .S_AXIS_TREADY(s_rdy[0]),
        .M_AXIS_TDATA(m_dat[0]), .M_AXIS_TLAST(m_last[0]), .M_AXIS_TVALID(m_vld[0]), .M_AXIS_TREADY(m_rdy),
        .flush(flush), .stat_clear(stat_clear),
        .data_count(dcnt[0]), .max_count(mcnt[0]), .drop_count(dropc[0]));

    axis_fifo_stats #(.TDATA_WIDTH(W), .FIFO_DEPTH(D), .DROP_WHEN_FULL(1)) dut_drop (
        .aclk(clk), .areset(areset),
        .S_AXIS_TDATA(s_dat), .S_AXIS_TLAST(s_last), .S_AXIS_TVALID(s_vld), .S_AXIS_TREADY(s_rdy[1]),
        .M_AXIS_TDATA(m_dat[1]), .M_AXIS_TLAST(m_last[1]), .M_AXIS_TVALID(m_vld[1]), .M_AXIS_TREADY(m_rdy),
        .flush(flush), .stat_clear(stat_clear),
        .data_count(dcnt[1]), .max_count(mcnt[1]), .drop_count(dropc[1]));

    typedef logic [W:0] beat_t;  // {last, data}
    beat_t       mq0[$];
    beat_t       mq1[$];
    bit          oor   [2];
    int unsigned mmax  [2];
    int unsigned mdrop [2];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic int qsize(input int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic beat_t qfront(input int d);
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_rdy(input int d);
        return oor[d] && (d == 1 || qsize(d) < D);
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int    sz;
            beat_t f;
            sz = qsize(d);
            chk($sformatf("d%0d_m_valid", d), 32'(m_vld[d]), 32'(sz > 0));
            chk($sformatf("d%0d_s_ready", d), 32'(s_rdy[d]), 32'(model_rdy(d)));
            chk($sformatf("d%0d_data_count", d), dcnt[d], 32'(sz));
            chk($sformatf("d%0d_max_count", d), mcnt[d], mmax[d]);
            chk($sformatf("d%0d_drop_count", d), dropc[d], mdrop[d]);
            if (sz > 0) begin
                f = qfront(d);
                chk($sformatf("d%0d_m_data", d), m_dat[d], f[W-1:0]);
                chk($sformatf("d%0d_m_last", d), 32'(m_last[d]), 32'(f[W]));
            end
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int sz, n;
            bit rdy, full, pop, acc, drp;
            sz = qsize(d);
            if (areset) begin
                if (d == 0) mq0.delete(); else mq1.delete();
                oor[d] = 0; mmax[d] = 0; mdrop[d] = 0;
            end else begin
                rdy  = model_rdy(d);
                full = (sz == D);
                pop  = (sz > 0) && m_rdy;
                acc  = s_vld && rdy && !flush && !full;
                drp  = s_vld && rdy && !flush && full;
                if (flush) begin
                    if (d == 0) mq0.delete(); else mq1.delete();
                end else begin
                    if (pop) begin
                        if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                    end
                    if (acc) begin
                        if (d == 0) mq0.push_back({s_last, s_dat}); else mq1.push_back({s_last, s_dat});
                    end
                end
                n = qsize(d);
                if (stat_clear) begin
                    mmax[d]  = n;
                    mdrop[d] = drp;
                end else begin
                    if (n > mmax[d]) mmax[d] = n;
                    if (drp && mdrop[d] != 32'hFFFF_FFFF) mdrop[d]++;
                end
                oor[d] = 1;
            end
        end
    endtask

    task automatic tick();
        check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        s_vld = 0; s_last = 0; flush = 0; stat_clear = 0;
    endtask

    initial begin
        areset = 1; m_rdy = 0; s_dat = '0;
        idle();
        for (int d = 0; d < 2; d++) begin oor[d] = 0; mmax[d] = 0; mdrop[d] = 0; end
        @(posedge clk); @(posedge clk); @(negedge clk);

        // Reset state and release
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_m_data", m_dat[d], 32'h0);
            chk("rst_m_last", 32'(m_last[d]), 32'h0);
        end
        areset = 0;
        tick();
        tick();

        // Latency and order, sink always ready
        m_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            s_vld = 1; s_dat = i; s_last = (i == 9);
            tick();
        end
        idle();
        tick(); tick();
        chk("lat_max_count", mcnt[0], 32'd1);

        // Fill past full with sink stalled: backpressure vs drop
        stat_clear = 1; tick(); idle();
        m_rdy = 0;
        for (int i = 0; i < 21; i++) begin
            s_vld = 1; s_dat = i; s_last = i[0];
            tick();
        end
        idle();
        tick();
        chk("full_count_bp", dcnt[0], 32'd16);
        chk("full_ready_bp", 32'(s_rdy[0]), 32'd0);
        chk("full_count_drop", dcnt[1], 32'd16);
        chk("full_drops", dropc[1], 32'd5);
        chk("full_head", m_dat[0], 32'd0);
        m_rdy = 1; tick();
        m_rdy = 0;
        chk("ready_reassert", 32'(s_rdy[0]), 32'd1);
        tick();
        m_rdy = 1;
        for (int i = 0; i < 18; i++) tick();

        // Flush at seven words with a write in the flush cycle
        m_rdy = 0;
        stat_clear = 1; tick(); idle();
        for (int i = 0; i < 7; i++) begin
            s_vld = 1; s_dat = 32'h100 + i; s_last = 0;
            tick();
        end
        s_vld = 1; s_dat = 32'hAA; flush = 1;
        tick();
        idle();
        chk("flush_count", dcnt[0], 32'd0);
        chk("flush_valid", 32'(m_vld[0]), 32'd0);
        chk("flush_max", mcnt[0], 32'd7);
        m_rdy = 1;
        tick(); tick();

        // Random valid/ready traffic
        for (int i = 0; i < 10000; i++) begin
            s_vld  = ($urandom % 2) == 1;
            m_rdy  = ($urandom % 2) == 1;
            s_dat  = $urandom;
            s_last = ($urandom % 4) == 0;
            tick();
            if (dcnt[0] > 16 || dcnt[1] > 16)
                chk("rand_count_bound", dcnt[0] > 16 ? dcnt[0] : dcnt[1], 32'd16);
        end
        idle();

        // Reset with nine words stored
        m_rdy = 0; flush = 1; tick(); idle();
        for (int i = 0; i < 9; i++) begin
            s_vld = 1; s_dat = 32'h200 + i; s_last = (i == 8);
            tick();
        end
        idle();
        chk("pre_rst_count", dcnt[0], 32'd9);
        areset = 1; tick();
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_valid", 32'(m_vld[d]), 32'd0);
            chk("mid_rst_ready", 32'(s_rdy[d]), 32'd0);
            chk("mid_rst_data", m_dat[d], 32'd0);
            chk("mid_rst_last", 32'(m_last[d]), 32'd0);
            chk("mid_rst_count", dcnt[d], 32'd0);
            chk("mid_rst_max", mcnt[d], 32'd0);
            chk("mid_rst_drop", dropc[d], 32'd0);
        end
        areset = 0; tick(); tick();

        // stat_clear with a simultaneous write at three words
        for (int i = 0; i < 3; i++) begin
            s_vld = 1; s_dat = 32'h300 + i; s_last = 0;
            tick();
        end
        s_dat = 32'h303; stat_clear = 1;
        tick();
        idle();
        chk("clr_max", mcnt[0], 32'd4);
        chk("clr_drop", dropc[0], 32'd0);
        chk("clr_count", dcnt[0], 32'd4);
        m_rdy = 1;
        for (int i = 0; i < 6; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_fifo_stats.md
Name: axis_fifo_stats

Overview:
- Parametrised synchronous AXI4-Stream FIFO for the data-capture path; successor to the fixed XPM-based stream FIFO wrapper.
- Inferred storage, TLAST carried through, registered output stage.
- Optional drop-when-full mode, synchronous flush, and a statistics block: fill level, high-water mark, drop counter.
- Sits between a capture/stream source and the DMA/readout, with counters exposed to the register file.

Parameters:
- TDATA_WIDTH, 128, payload width in bits, 8..1024.
- FIFO_DEPTH, 256, total words held including the output stage; power of 2, 4..4096.
- DROP_WHEN_FULL, 0, 0 = backpressure when full; 1 = always ready and discard beats that arrive when full.
- COUNT_WIDTH, $clog2(FIFO_DEPTH)+1, internal fill-counter width (derived; do not override).

Ports:
- aclk  in  1  sole clock, rising edge.
- areset  in  1  synchronous active-high reset.
- S_AXIS_TDATA  in  TDATA_WIDTH  input payload.
- S_AXIS_TLAST  in  1  input packet boundary.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  TDATA_WIDTH  output payload.
- M_AXIS_TLAST  out  1  output packet boundary.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  output ready.
- flush  in  1  one-cycle pulse; discards all stored words.
- stat_clear  in  1  one-cycle pulse; clears max_count and drop_count.
- data_count  out  32  current words stored, zero-extended.
- max_count  out  32  high-water mark of data_count since last clear.
- drop_count  out  32  beats discarded in drop mode; saturates at 0xFFFFFFFF.

Behaviour:
- Clock and reset: aclk only. areset is synchronous and active-high.
- Reset values:
  - S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0.
  - data_count=0, max_count=0, drop_count=0.
  - Read and write pointers = 0.
- Reset mid-operation: contents are lost. TREADY rises on the first edge after areset deasserts.
- Accept: a beat is accepted on an edge where S_AXIS_TVALID && S_AXIS_TREADY.
- Output: a beat leaves on an edge where M_AXIS_TVALID && M_AXIS_TREADY.
- Storage: FIFO_DEPTH-1 entry RAM plus a one-word output register. data_count counts both.
- Latency: a beat accepted at edge E into an empty FIFO is presented on M_AXIS from edge E+1 (one-cycle latency).
- Throughput: 1 beat/cycle sustained when M_AXIS_TREADY=1.
- Output stability: M_AXIS_TDATA/TLAST are held stable while TVALID=1 && TREADY=0. TVALID never drops without a handshake, except on flush or reset.
- Order: strict FIFO order. TLAST travels with its word.
- data_count update each edge: next = count + accept - output.
  - Simultaneous accept and output leaves it unchanged.
  - Range is 0..FIFO_DEPTH.
- Full, DROP_WHEN_FULL=0:
  - S_AXIS_TREADY = (data_count < FIFO_DEPTH), registered.
  - When full, TREADY=0 even if an output handshake occurs the same cycle. TREADY reasserts the next cycle.
- Full, DROP_WHEN_FULL=1:
  - S_AXIS_TREADY=1 whenever not in reset.
  - A valid beat arriving while data_count==FIFO_DEPTH is discarded, with no state change except drop_count += 1 (saturating).
  - An output handshake in that same cycle does not rescue the beat.
- Empty: M_AXIS_TVALID=0. Pointers wrap modulo FIFO_DEPTH-1 without error.
- Flush:
  - Next edge: pointers reset, data_count=0, M_AXIS_TVALID=0.
  - Any S beat accepted in the flush cycle is discarded, and is not counted as a drop.
  - max_count and drop_count are not affected.
- max_count:
  - On each edge, if next data_count > max_count, max_count <= next data_count.
  - stat_clear: max_count <= next data_count.
  - stat_clear: drop_count <= 1 if a drop occurs that cycle, else 0.
- Overflow: no X or undefined states at any full, empty, or wrap boundary.

Test Plan (TDATA_WIDTH=32, FIFO_DEPTH=16 unless noted):
- Latency and order: M_AXIS_TREADY=1; write 0x0..0x9, TLAST on 0x9.
  - Each word appears one cycle after acceptance, in order.
  - TLAST only with 0x9.
  - data_count peaks at 1; max_count=1.
- Fill to full, DROP_WHEN_FULL=0, M_AXIS_TREADY=0: write 20 beats.
  - 16 accepted; data_count=16; S_AXIS_TREADY=0.
  - One read reasserts TREADY the next cycle.
  - Drain yields beats 0..15 in order.
- Drop mode, DROP_WHEN_FULL=1: fill 16, then present 5 more with M_AXIS_TREADY=0.
  - drop_count=5; data_count=16.
  - Drain yields 0..15.
- Flush at data_count=7 while S is writing 0xAA:
  - Next cycle data_count=0, M_AXIS_TVALID=0.
  - 0xAA is not output; max_count stays 7.
- Random backpressure: 10,000 beats, TVALID and TREADY each 50% random.
  - Scoreboard matches exactly, TLAST included.
  - data_count never exceeds 16; M_AXIS held stable during stalls.
- Reset at data_count=9; stat_clear at data_count=3 with a simultaneous write:
  - Reset: all outputs zero.
  - stat_clear case: max_count=4, drop_count=0.
